// File: rtl/inst_fetcher.sv
// Front-end fetch stage: fetch PC, direct-mapped icache refilled from the memory controller, next-PC prediction.
// Optional macro BHT_EN: 2-bit saturating branch history table; without it, branches use static backward-taken.
module inst_fetcher #(
  parameter int ICACHE_IDX_W = 8,
  parameter int BHT_IDX_W    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_full,
  input  logic        rs_full,
  input  logic        lsb_full,
  input  logic        rollback_flag_from_rob,
  input  logic [31:0] target_pc_from_rob,
  input  logic        bht_upd_en_from_rob,
  input  logic [31:0] bht_upd_pc_from_rob,
  input  logic        bht_upd_taken_from_rob,
  output logic        req_to_mc,
  output logic [31:0] addr_to_mc,
  input  logic        valid_from_mc,
  input  logic [31:0] inst_from_mc,
  output logic        rdy_flag_to_dispatcher,
  output logic [31:0] inst_to_dispatcher,
  output logic [31:0] pc_to_dispatcher,
  output logic        predicted_jump_flag,
  output logic [31:0] rollback_pc_to_dispatcher
);

  localparam int TAG_W   = 32 - ICACHE_IDX_W - 2;
  localparam int ENTRIES = 1 << ICACHE_IDX_W;

  typedef enum logic [1:0] {IDLE, WAIT_MC, DRAIN} state_t;

  state_t r_state, w_state_nxt;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag  [ENTRIES];
  logic [31:0]        r_data [ENTRIES];

  logic [31:0] r_pc;
  logic        r_req;
  logic [31:0] r_addr;
  logic        r_rdy_flag;
  logic [31:0] r_inst_out;
  logic [31:0] r_pc_out;
  logic        r_pred;
  logic [31:0] r_rb_pc;

  logic [ICACHE_IDX_W-1:0] w_idx, w_wr_idx;
  logic        w_hit, w_stall, w_br_taken;
  logic [31:0] w_inst, w_imm_j, w_imm_b, w_pc_plus4, w_tgt_j, w_tgt_b;
  logic [31:0] w_next_pc, w_rb_pc;
  logic        w_pred;
  logic        w_issue, w_req_set, w_req_clr, w_cache_we;

  assign w_idx      = r_pc[ICACHE_IDX_W+1:2];
  assign w_wr_idx   = r_addr[ICACHE_IDX_W+1:2];
  assign w_inst     = r_data[w_idx];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == r_pc[31:ICACHE_IDX_W+2]);
  assign w_stall    = rob_full | rs_full | lsb_full;

  assign w_imm_j    = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
  assign w_imm_b    = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_tgt_j    = r_pc + w_imm_j;
  assign w_tgt_b    = r_pc + w_imm_b;

`ifdef BHT_EN
  logic [1:0] r_bht [1 << BHT_IDX_W];
  logic       w_unused_bht;

  assign w_br_taken   = r_bht[r_pc[BHT_IDX_W+1:2]][1];
  assign w_unused_bht = ^{bht_upd_pc_from_rob[31:BHT_IDX_W+2], bht_upd_pc_from_rob[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < (1 << BHT_IDX_W); i++) r_bht[i] <= 2'b01;
    end else if (rdy && bht_upd_en_from_rob) begin
      if (bht_upd_taken_from_rob) begin
        if (r_bht[bht_upd_pc_from_rob[BHT_IDX_W+1:2]] != 2'b11)
          r_bht[bht_upd_pc_from_rob[BHT_IDX_W+1:2]] <= r_bht[bht_upd_pc_from_rob[BHT_IDX_W+1:2]] + 2'b01;
      end else begin
        if (r_bht[bht_upd_pc_from_rob[BHT_IDX_W+1:2]] != 2'b00)
          r_bht[bht_upd_pc_from_rob[BHT_IDX_W+1:2]] <= r_bht[bht_upd_pc_from_rob[BHT_IDX_W+1:2]] - 2'b01;
      end
    end
  end
`else
  logic w_unused_bht;

  assign w_br_taken   = w_imm_b[31];
  assign w_unused_bht = ^{bht_upd_en_from_rob, bht_upd_pc_from_rob, bht_upd_taken_from_rob};
`endif

  // rollback_pc always carries the path not taken, so the dispatcher can recover either way
  always_comb begin
    w_next_pc = w_pc_plus4;
    w_pred    = 1'b0;
    w_rb_pc   = w_pc_plus4;
    case (w_inst[6:0])
      7'b1101111: begin
        w_next_pc = w_tgt_j;
        w_pred    = 1'b1;
      end
      7'b1100011: begin
        if (w_br_taken) begin
          w_next_pc = w_tgt_b;
          w_pred    = 1'b1;
        end else begin
          w_rb_pc   = w_tgt_b;
        end
      end
      default: ;
    endcase
  end

  // Rollback overrides issue; a word arriving with the rollback is still valid for its own address
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_req_set   = 1'b0;
    w_req_clr   = 1'b0;
    w_cache_we  = 1'b0;
    if (rollback_flag_from_rob) begin
      case (r_state)
        WAIT_MC: begin
          w_req_clr = 1'b1;
          if (valid_from_mc) begin
            w_cache_we  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DRAIN;
          end
        end
        DRAIN:   if (valid_from_mc) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            w_issue = !w_stall;
          end else begin
            w_req_set   = 1'b1;
            w_state_nxt = WAIT_MC;
          end
        end
        WAIT_MC: begin
          if (valid_from_mc) begin
            w_cache_we  = 1'b1;
            w_req_clr   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        DRAIN:   if (valid_from_mc) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else if (rdy) r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= '0;
      r_valid    <= '0;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_rdy_flag <= 1'b0;
      r_inst_out <= '0;
      r_pc_out   <= '0;
      r_pred     <= 1'b0;
      r_rb_pc    <= '0;
    end else if (rdy) begin
      if (w_cache_we) r_valid[w_wr_idx] <= 1'b1;
      if (w_req_set) begin
        r_req  <= 1'b1;
        r_addr <= {r_pc[31:2], 2'b00};
      end else if (w_req_clr) begin
        r_req  <= 1'b0;
      end
      r_rdy_flag <= w_issue;
      if (w_issue) begin
        r_inst_out <= w_inst;
        r_pc_out   <= r_pc;
        r_pred     <= w_pred;
        r_rb_pc    <= w_rb_pc;
      end
      if (rollback_flag_from_rob) r_pc <= target_pc_from_rob;
      else if (w_issue)           r_pc <= w_next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && w_cache_we) begin
      r_tag[w_wr_idx]  <= r_addr[31:ICACHE_IDX_W+2];
      r_data[w_wr_idx] <= inst_from_mc;
    end
  end

  assign req_to_mc                 = r_req;
  assign addr_to_mc                = r_addr;
  assign rdy_flag_to_dispatcher    = r_rdy_flag;
  assign inst_to_dispatcher        = r_inst_out;
  assign pc_to_dispatcher          = r_pc_out;
  assign predicted_jump_flag       = r_pred;
  assign rollback_pc_to_dispatcher = r_rb_pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: memory-controller model, issue/request monitors, vector table plus sequences.
module tb_inst_fetcher;

  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  logic        rob_full = 1'b0, rs_full = 1'b0, lsb_full = 1'b0;
  logic        rollback = 1'b0;
  logic [31:0] target = '0;
  logic        bht_en = 1'b0, bht_taken = 1'b0;
  logic [31:0] bht_pc = '0;
  logic        valid_mc = 1'b0;
  logic [31:0] inst_mc = '0;
  logic        req_to_mc, rdy_flag, pred;
  logic [31:0] addr_to_mc, inst_to, pc_to, rb_pc;

  inst_fetcher #(.ICACHE_IDX_W(8), .BHT_IDX_W(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .rollback_flag_from_rob(rollback), .target_pc_from_rob(target),
    .bht_upd_en_from_rob(bht_en), .bht_upd_pc_from_rob(bht_pc), .bht_upd_taken_from_rob(bht_taken),
    .req_to_mc(req_to_mc), .addr_to_mc(addr_to_mc),
    .valid_from_mc(valid_mc), .inst_from_mc(inst_mc),
    .rdy_flag_to_dispatcher(rdy_flag), .inst_to_dispatcher(inst_to), .pc_to_dispatcher(pc_to),
    .predicted_jump_flag(pred), .rollback_pc_to_dispatcher(rb_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
    logic [31:0] rb;
  } iss_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
    logic [31:0] rb;
    logic [31:0] nxt;
  } vec_t;

  logic [31:0] mem [0:1023];
  iss_t        iss_q[$];
  logic [31:0] req_q[$];
  bit          mon_en = 1'b1;
  int          mc_lat = 3;
  int          n_cmp = 0, n_fail = 0;

  // Memory controller: latches the address when a request appears, answers mc_lat cycles later
  bit          mc_busy = 1'b0;
  int          mc_cnt = 0;
  logic [31:0] mc_addr = '0;
  initial begin
    forever begin
      @(posedge clk); #1;
      valid_mc = 1'b0;
      if (mc_busy) begin
        if (mc_cnt <= 0) begin
          valid_mc = 1'b1;
          inst_mc  = mem[mc_addr[11:2]];
          mc_busy  = 1'b0;
        end else begin
          mc_cnt--;
        end
      end else if (req_to_mc) begin
        mc_busy = 1'b1;
        mc_addr = addr_to_mc;
        mc_cnt  = mc_lat - 1;
      end
    end
  end

  logic prev_req = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rdy_flag) iss_q.push_back('{pc_to, inst_to, pred, rb_pc});
      if (req_to_mc && !prev_req) req_q.push_back(addr_to_mc);
      prev_req = req_to_mc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic timed_out(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  task automatic wait_issue(input string nm, output iss_t e);
    bit ok = 1'b0;
    e = '{32'hx, 32'hx, 1'bx, 32'hx};
    for (int i = 0; i < 300; i++) begin
      if (iss_q.size() > 0) begin
        e  = iss_q.pop_front();
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    if (!ok) timed_out(nm);
  endtask

  task automatic wait_req(input string nm, output logic [31:0] a);
    bit ok = 1'b0;
    a = 32'hx;
    for (int i = 0; i < 300; i++) begin
      if (req_q.size() > 0) begin
        a  = req_q.pop_front();
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    if (!ok) timed_out(nm);
  endtask

  task automatic do_rollback(input logic [31:0] t);
    @(posedge clk); #1;
    rollback = 1'b1;
    target   = t;
    @(posedge clk); #1;
    rollback = 1'b0;
    iss_q.delete();
    req_q.delete();
  endtask

  function automatic logic [31:0] loop_next(input logic [31:0] p);
    return (p == 32'h20C) ? 32'h200 : p + 32'd4;
  endfunction

  vec_t        tbl[6];
  iss_t        e;
  logic [31:0] a, tpc, last_pc, snap_pc;
  int          sz, hi_cnt, bad_seq;

  initial begin
    tbl[0] = '{32'h0000_0010, 32'h0200_006F, 1'b1, 32'h0000_0014, 32'h0000_0030};
`ifdef BHT_EN
    tbl[1] = '{32'h0000_0040, 32'hFE00_0CE3, 1'b0, 32'h0000_0038, 32'h0000_0044};
`else
    tbl[1] = '{32'h0000_0040, 32'hFE00_0CE3, 1'b1, 32'h0000_0044, 32'h0000_0038};
`endif
    tbl[2] = '{32'h0000_0080, 32'h0000_0863, 1'b0, 32'h0000_0090, 32'h0000_0084};
    tbl[3] = '{32'h0000_00C0, 32'h0000_8067, 1'b0, 32'h0000_00C4, 32'h0000_00C4};
    tbl[4] = '{32'h0000_0140, 32'h0000_0013, 1'b0, 32'h0000_0144, 32'h0000_0144};
    tbl[5] = '{32'hFFFF_FFF8, 32'h0100_006F, 1'b1, 32'hFFFF_FFFC, 32'h0000_0008};

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0013;
    for (int i = 0; i < 6; i++) begin
      tpc = tbl[i].pc;
      mem[tpc[11:2]] = tbl[i].inst;
    end
    mem[32'h20C >> 2] = 32'hFF5F_F06F;
    mem[32'h300 >> 2] = 32'h0010_0093;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",      {31'b0, req_to_mc}, 32'd0);
    chk("rst_addr",     addr_to_mc, 32'd0);
    chk("rst_rdy_flag", {31'b0, rdy_flag}, 32'd0);
    chk("rst_inst",     inst_to, 32'd0);
    chk("rst_pc",       pc_to, 32'd0);
    chk("rst_pred",     {31'b0, pred}, 32'd0);
    chk("rst_rb_pc",    rb_pc, 32'd0);
    rst = 1'b0;

    wait_req("t1_req", a);
    chk("t1_req_addr", a, 32'd0);
    wait_issue("t1_issue", e);
    chk("t1_pc", e.pc, 32'd0);
    chk("t1_inst", e.inst, 32'h0000_0013);
    wait_issue("t1_issue2", e);
    chk("t1_single_pulse_next_pc", e.pc, 32'd4);

    for (int i = 0; i < 6; i++) begin
      do_rollback(tbl[i].pc);
      wait_issue("vec_issue", e);
      chk($sformatf("vec%0d_pc", i),    e.pc, tbl[i].pc);
      chk($sformatf("vec%0d_inst", i),  e.inst, tbl[i].inst);
      chk($sformatf("vec%0d_pred", i),  {31'b0, e.pred}, {31'b0, tbl[i].pred});
      chk($sformatf("vec%0d_rb", i),    e.rb, tbl[i].rb);
      wait_issue("vec_issue_next", e);
      chk($sformatf("vec%0d_next", i),  e.pc, tbl[i].nxt);
    end

    // Four-word loop: once warm it must issue every cycle without touching the mc
    do_rollback(32'h200);
    sz = 0;
    for (int i = 0; i < 12 && sz < 2; i++) begin
      wait_issue("loop_warm", e);
      if (e.pc == 32'h20C) sz++;
    end
    req_q.delete();
    iss_q.delete();
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rdy_flag) hi_cnt++;
    end
    @(negedge clk); #1;
    bad_seq = 0;
    for (int i = 1; i < iss_q.size(); i++)
      if (iss_q[i].pc != loop_next(iss_q[i-1].pc)) bad_seq++;
    chk("loop_pulses", hi_cnt, 8);
    chk("loop_order", bad_seq, 0);
    chk("loop_no_req", req_q.size(), 0);

    // rob_full for 5 cycles on a hit
    @(posedge clk); #1;
    rob_full = 1'b1;
    @(negedge clk); #1;
    last_pc = iss_q[iss_q.size()-1].pc;
    sz      = iss_q.size();
    hi_cnt  = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rdy_flag) hi_cnt++;
    end
    chk("stall_rdy_low", hi_cnt, 0);
    chk("stall_no_issue", iss_q.size(), sz);
    rob_full = 1'b0;
    @(posedge clk); #1;
    chk("stall_release_flag", {31'b0, rdy_flag}, 32'd1);
    chk("stall_release_pc", pc_to, loop_next(last_pc));
    @(posedge clk); #1;
    chk("stall_once_pc", pc_to, loop_next(loop_next(last_pc)));

    // rdy low freezes everything, outputs included
    mon_en  = 1'b0;
    rdy     = 1'b0;
    snap_pc = pc_to;
    repeat (3) @(posedge clk);
    #1;
    chk("rdy_hold_pc", pc_to, snap_pc);
    chk("rdy_hold_flag", {31'b0, rdy_flag}, 32'd1);
    rdy = 1'b1;
    @(posedge clk); #1;
    chk("rdy_resume_pc", pc_to, loop_next(snap_pc));
    mon_en = 1'b1;

    // Rollback while waiting on the mc: word for the abandoned address must not be cached
    mc_lat = 8;
    do_rollback(32'h300);
    wait_req("drain_req0", a);
    chk("drain_req0_addr", a, 32'h300);
    @(posedge clk); #1;
    rollback = 1'b1;
    target   = 32'h100;
    @(posedge clk); #1;
    rollback = 1'b0;
    iss_q.delete();
    req_q.delete();
    chk("drain_req_dropped", {31'b0, req_to_mc}, 32'd0);
    wait_req("drain_req1", a);
    chk("drain_next_req_addr", a, 32'h100);
    wait_issue("drain_issue", e);
    chk("drain_issue_pc", e.pc, 32'h100);
    do_rollback(32'h300);
    wait_req("drain_refetch", a);
    chk("drain_not_cached_req", a, 32'h300);
    wait_issue("drain_refetch_issue", e);
    chk("drain_refetch_inst", e.inst, 32'h0010_0093);

`ifdef BHT_EN
    @(posedge clk); #1;
    bht_en    = 1'b1;
    bht_pc    = 32'h40;
    bht_taken = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bht_en = 1'b0;
    do_rollback(32'h40);
    wait_issue("bht_issue", e);
    chk("bht_pc", e.pc, 32'h40);
    chk("bht_pred", {31'b0, e.pred}, 32'd1);
    chk("bht_rb", e.rb, 32'h44);
    wait_issue("bht_issue_next", e);
    chk("bht_next", e.pc, 32'h38);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
